// File: rtl/acs_pkg.sv
// Shared types, constants and the trellis codeword helper for the ACS array.
package acs_pkg;

    localparam int K_MAX = 7;
    localparam int SI_W = K_MAX - 1;

    // Metric state loaded by reset and by an accepted start symbol
    localparam int PM_START = 0;
    localparam int START_STATE = 0;

    typedef logic [SI_W-1:0] state_idx_t;

    function automatic logic [1:0] codeword(
        input int         k,
        input int         g0,
        input int         g1,
        input state_idx_t p,
        input logic       b
    );
        logic [31:0] r;
        r = (32'(b) << (k - 1)) | 32'(p);
        return {^(r & 32'(g0)), ^(r & 32'(g1))};
    endfunction

endpackage

// File: rtl/acs_if.sv
// Symbol-in / decision-out handshake bundle of the ACS array.
interface acs_if #(
    parameter int K   = 3,
    parameter int BMW = 2,
    parameter int PMW = 8
);
    localparam int NS = 1 << (K - 1);

    logic             in_valid;
    logic             in_ready;
    logic             start;
    logic [4*BMW-1:0] bm;
    logic             out_valid;
    logic             out_ready;
    logic [NS-1:0]    dec;
    logic [NS-1:0]    st_valid;
    logic [K-2:0]     best_state;
    logic [PMW-1:0]   best_metric;

    modport master (
        output in_valid, start, bm, out_ready,
        input  in_ready, out_valid, dec, st_valid,
        input  best_state, best_metric
    );

    modport slave (
        input  in_valid, start, bm, out_ready,
        output in_ready, out_valid, dec, st_valid,
        output best_state, best_metric
    );

endinterface

// File: rtl/acs_array_cell.sv
// Combinational add-compare-select for one trellis state.
module acs_cell #(
    parameter int BMW = 2,
    parameter int PMW = 8
) (
    input  logic [PMW-1:0] pm0_i,
    input  logic [PMW-1:0] pm1_i,
    input  logic           v0_i,
    input  logic           v1_i,
    input  logic [BMW-1:0] bm0_i,
    input  logic [BMW-1:0] bm1_i,
    output logic           dec_o,
    output logic           valid_o,
    output logic [PMW:0]   sum_o
);

    logic [PMW:0] cost0;
    logic [PMW:0] cost1;

    assign cost0 = {1'b0, pm0_i} + (PMW+1)'(bm0_i);
    assign cost1 = {1'b0, pm1_i} + (PMW+1)'(bm1_i);
    assign valid_o = v0_i | v1_i;

    always_comb begin
        dec_o = 1'b0;
        sum_o = '0;
        unique case (1'b1)
            (v0_i && v1_i): begin
                // ties keep the even predecessor
                if (cost0 > cost1) begin
                    dec_o = 1'b1;
                    sum_o = cost1;
                end else begin
                    sum_o = cost0;
                end
            end
            (v0_i && !v1_i): sum_o = cost0;
            (!v0_i && v1_i): begin
                dec_o = 1'b1;
                sum_o = cost1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acs_array.sv
// Registered ACS array: one trellis step per accepted symbol.
// Define ACS_NORM_EN for MSB normalisation instead of saturation.
module acs_array
    import acs_pkg::*;
#(
    parameter int K   = 3,
    parameter int G0  = 7,
    parameter int G1  = 5,
    parameter int BMW = 2,
    parameter int PMW = 8
) (
    input logic  clk,
    input logic  rst_n,
    acs_if.slave io
);

    localparam int NS = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam logic [NS-1:0] VLD_INIT = NS'(1) << START_STATE;

    logic [NS-1:0][PMW-1:0] pm_q, pm_d, pm_base;
    logic [NS-1:0][PMW:0]   sum;
    logic [NS-1:0]          vld_q, vld_d, vld_base;
    logic [NS-1:0]          dec_q, dec_d;
    logic [SW-1:0]          best_state_q, best_state_d;
    logic [PMW-1:0]         best_metric_q, best_metric_d;
    logic                   out_valid_q;
    logic                   accept;
    logic                   found;

    assign io.in_ready = !out_valid_q || io.out_ready;
    assign accept = io.in_valid && io.in_ready;

    always_comb begin
        pm_base = {NS{PMW'(PM_START)}};
        vld_base = VLD_INIT;
        if (!io.start) begin
            pm_base = pm_q;
            vld_base = vld_q;
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_cell
        localparam int P0 = (s << 1) & (NS - 1);
        localparam int P1 = P0 | 1;
        localparam logic B = ((s >> (K - 2)) & 1) != 0;
        localparam int CW0 =
            int'(codeword(K, G0, G1, state_idx_t'(P0), B));
        localparam int CW1 =
            int'(codeword(K, G0, G1, state_idx_t'(P1), B));

        acs_cell #(
            .BMW (BMW),
            .PMW (PMW)
        ) u_cell (
            .pm0_i   (pm_base[P0]),
            .pm1_i   (pm_base[P1]),
            .v0_i    (vld_base[P0]),
            .v1_i    (vld_base[P1]),
            .bm0_i   (io.bm[CW0*BMW +: BMW]),
            .bm1_i   (io.bm[CW1*BMW +: BMW]),
            .dec_o   (dec_d[s]),
            .valid_o (vld_d[s]),
            .sum_o   (sum[s])
        );
    end

`ifdef ACS_NORM_EN
    logic norm;

    always_comb begin
        norm = |vld_d;
        for (int s = 0; s < NS; s++) begin
            pm_d[s] = sum[s][PMW-1:0];
            if (vld_d[s] && !sum[s][PMW-1]) norm = 1'b0;
        end
        // subtracting 2^(PMW-1) from every state keeps differences
        if (norm) begin
            for (int s = 0; s < NS; s++) pm_d[s][PMW-1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            for (int s = 0; s < NS; s++) assert (!sum[s][PMW]);
        end
    end
`else
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            pm_d[s] = sum[s][PMW] ? '1 : sum[s][PMW-1:0];
        end
    end
`endif

    always_comb begin
        found = 1'b0;
        best_state_d = '0;
        best_metric_d = '0;
        for (int s = 0; s < NS; s++) begin
            if (vld_d[s] && (!found || pm_d[s] < best_metric_d)) begin
                found = 1'b1;
                best_state_d = SW'(s);
                best_metric_d = pm_d[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q <= '0;
            vld_q <= VLD_INIT;
            dec_q <= '0;
            best_state_q <= '0;
            best_metric_q <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            pm_q <= pm_d;
            vld_q <= vld_d;
            dec_q <= dec_d;
            best_state_q <= best_state_d;
            best_metric_q <= best_metric_d;
            out_valid_q <= 1'b1;
        end else if (io.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.dec = dec_q;
    assign io.st_valid = vld_q;
    assign io.best_state = best_state_q;
    assign io.best_metric = best_metric_q;

endmodule

// File: tb/tb_acs_array.sv
// Directed-vector bench for acs_array with K=3, G0=7, G1=5.
module tb_acs_array;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_run = 0;
    int n_fail = 0;
    int hs = 0;
    int hs0;
    int m;
    logic [7:0] mb;

    always #5 clk = ~clk;

    acs_if #(.K(3), .BMW(2), .PMW(8)) io ();

    acs_array #(
        .K   (3),
        .G0  (7),
        .G1  (5),
        .BMW (2),
        .PMW (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always @(posedge clk) if (io.out_valid && io.out_ready) hs++;

    typedef struct {
        logic        start;
        logic [7:0]  bm;
        logic [3:0]  vld;
        logic [3:0]  dec;
        logic [1:0]  bs;
        logic [7:0]  bmet;
        logic [31:0] pm;
    } vec_t;

    vec_t tv[10];

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(string tag, logic [3:0] vld,
                             logic [3:0] dec, logic [1:0] bs,
                             logic [7:0] bmet, logic [31:0] pm);
        check({tag, ".st_valid"}, 32'(io.st_valid), 32'(vld));
        check({tag, ".dec"}, 32'(io.dec), 32'(dec));
        check({tag, ".best_state"}, 32'(io.best_state), 32'(bs));
        check({tag, ".best_metric"}, 32'(io.best_metric), 32'(bmet));
        check({tag, ".pm"}, dut.pm_q, pm);
    endtask

    initial begin
        // bm byte = {slice3, slice2, slice1, slice0}
        tv[0] = '{1'b1, 8'h16, 4'h5, 4'h0, 2'd2, 8'd0, 32'h00000002};
        tv[1] = '{1'b0, 8'h16, 4'hF, 4'h0, 2'd1, 8'd1, 32'h01020104};
        tv[2] = '{1'b1, 8'hA8, 4'h5, 4'h0, 2'd0, 8'd0, 32'h00020000};
        for (int i = 3; i < 8; i++)
            tv[i] = '{1'b0, 8'hA8, 4'hF, 4'h0, 2'd0, 8'd0, 32'h04020400};
        tv[8] = '{1'b0, 8'h08, 4'hF, 4'h0, 2'd0, 8'd0, 32'h04000200};
        tv[9] = '{1'b0, 8'h03, 4'hF, 4'h1, 2'd1, 8'd0, 32'h00000002};

        io.in_valid = 1'b0;
        io.start = 1'b0;
        io.bm = '0;
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 32'(io.out_valid), 32'd0);
        check("rst.in_ready", 32'(io.in_ready), 32'd1);
        check_out("rst", 4'h1, 4'h0, 2'd0, 8'd0, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            io.in_valid = 1'b1;
            io.start = tv[i].start;
            io.bm = tv[i].bm;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.out_valid", i), 32'(io.out_valid), 32'd1);
            check_out($sformatf("v%0d", i), tv[i].vld, tv[i].dec,
                      tv[i].bs, tv[i].bmet, tv[i].pm);
        end
        @(negedge clk) io.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain.out_valid", 32'(io.out_valid), 32'd0);

        // backpressure: result held while out_ready is low
        @(negedge clk);
        io.in_valid = 1'b1;
        io.start = 1'b1;
        io.bm = 8'hA8;
        io.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp.out_valid", 32'(io.out_valid), 32'd1);
        check_out("bp0", 4'h5, 4'h0, 2'd0, 8'd0, 32'h00020000);
        @(negedge clk);
        io.start = 1'b0;
        io.bm = 8'h03;
        hs0 = hs;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d.in_ready", c), 32'(io.in_ready), 32'd0);
            check_out($sformatf("bp%0d", c), 4'h5, 4'h0, 2'd0, 8'd0,
                      32'h00020000);
        end
        @(negedge clk);
        io.out_ready = 1'b1;
        io.bm = 8'hA8;
        #1;
        check("rel.in_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rel.out_valid", 32'(io.out_valid), 32'd1);
        check("rel.handshakes", 32'(hs - hs0), 32'd1);
        check_out("rel", 4'hF, 4'h0, 2'd0, 8'd0, 32'h04020400);
        @(negedge clk) io.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rel2.out_valid", 32'(io.out_valid), 32'd0);
        check("rel2.handshakes", 32'(hs - hs0), 32'd2);

        // metric growth under all-maximum branch metrics
        @(negedge clk);
        io.in_valid = 1'b1;
        io.start = 1'b1;
        io.bm = 8'hFF;
        m = 3;
        @(posedge clk);
        #1;
        check_out("grow1", 4'h5, 4'h0, 2'd0, 8'd3, 32'h00030003);
        for (int st = 2; st <= 200; st++) begin
            @(negedge clk) io.start = 1'b0;
            @(posedge clk);
            #1;
            m = m + 3;
`ifdef ACS_NORM_EN
            if (m >= 128) m = m - 128;
`else
            if (m > 255) m = 255;
`endif
            mb = 8'(m);
            check($sformatf("grow%0d.best_metric", st),
                  32'(io.best_metric), 32'(mb));
            check($sformatf("grow%0d.pm", st), dut.pm_q,
                  {mb, mb, mb, mb});
        end
        check("grow.st_valid", 32'(io.st_valid), 32'hF);

        // reset while a result is pending
        @(negedge clk);
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("mid.out_valid_pre", 32'(io.out_valid), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid.out_valid", 32'(io.out_valid), 32'd0);
        check_out("mid", 4'h1, 4'h0, 2'd0, 8'd0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
